// File: rtl/input_mems_pkg.sv
`default_nettype none
// ============================================================================
// Package  : input_mems_pkg
// Brief    : Shared types and helpers for the ping-pong accelerator input
//            memory (write FSM states, bank occupancy, K clamping).
// Revision : 1.0 - initial release
// ============================================================================
package input_mems_pkg;

    // Write-side load sequencer states
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_LOAD    = 3'd1,
        B_LOAD    = 3'd2,
        X_LOAD    = 3'd3,
        WAIT_FREE = 3'd4
    } wr_state_t;

    // Occupancy of one X bank
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_state_t;

    // A requested K of 0 is treated as 1; anything above the maximum saturates.
    function automatic int unsigned clamp_k(input int unsigned k_raw, input int unsigned max_k);
        if (k_raw == 0) begin
            return 1;
        end else if (k_raw > max_k) begin
            return max_k;
        end else begin
            return k_raw;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/input_mems_pingpong_mem.sv
`default_nettype none
// ============================================================================
// Module   : input_mems_pingpong_mem
// Brief    : Simple dual-port RAM, synchronous write, registered 1-cycle read.
//            Contents are not initialised.
// Revision : 1.0 - initial release
// ============================================================================
module input_mems_pingpong_mem #(
    parameter int WIDTH     = 24,
    parameter int DEPTH     = 72,
    parameter int ADDR_BITS = 7
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Write port and registered read port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/input_mems_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : input_mems_pingpong
// Brief    : Double-buffered X/W/K/B input memory. The conv core reads the
//            active set while the AXIS side loads the next one.
// Revision : 1.0 - initial release
// ============================================================================
module input_mems_pingpong
    import input_mems_pkg::*;
#(
    parameter  int INW         = 24,
    parameter  int R           = 9,
    parameter  int C           = 8,
    parameter  int MAXK        = 4,
    localparam int K_BITS      = $clog2(MAXK + 1),
    localparam int X_ADDR_BITS = $clog2(R * C),
    localparam int W_ADDR_BITS = $clog2(MAXK * MAXK)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [INW-1:0]         AXIS_TDATA,
    input  logic                   AXIS_TVALID,
    input  logic [K_BITS:0]        AXIS_TUSER,
    output logic                   AXIS_TREADY,
    output logic                   inputs_loaded,
    input  logic                   compute_finished,
    output logic [K_BITS-1:0]      K,
    output logic signed [INW-1:0]  B,
    input  logic [X_ADDR_BITS-1:0] X_read_addr,
    output logic signed [INW-1:0]  X_data,
    input  logic [W_ADDR_BITS-1:0] W_read_addr,
    output logic signed [INW-1:0]  W_data
);

    localparam int                  CNT_BITS = (X_ADDR_BITS > W_ADDR_BITS) ? X_ADDR_BITS : W_ADDR_BITS;
    localparam logic [CNT_BITS-1:0] X_LAST   = CNT_BITS'(R * C - 1);

    wr_state_t             state_q, state_d;
    bank_state_t           bank_q [2];
    bank_state_t           bank_d [2];
    logic                  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic                  rdy_q;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    // Set under construction
    logic [K_BITS-1:0]     cur_k_q, cur_k_d;
    logic                  cur_wsel_q, cur_wsel_d;
    logic [INW-1:0]        cur_b_q, cur_b_d;
    // Most recently completed set, reused when a set arrives without new W
    logic [K_BITS-1:0]     last_k_q, last_k_d;
    logic                  last_wsel_q, last_wsel_d;
    logic [INW-1:0]        last_b_q, last_b_d;
    // Per-X-bank attributes
    logic [K_BITS-1:0]     x_k_q [2];
    logic [K_BITS-1:0]     x_k_d [2];
    logic                  x_wsel_q [2];
    logic                  x_wsel_d [2];
    logic [INW-1:0]        x_b_q [2];
    logic [INW-1:0]        x_b_d [2];
    // Read-data output mux selects, aligned with the 1-cycle RAM latency
    logic                  x_sel_q, w_sel_q;

    logic                  tready, beat, x_we, w_we, w_bank_wr, w_sel_new;
    logic [K_BITS-1:0]     k_clamped;
    logic [CNT_BITS-1:0]   w_last;
    logic [INW-1:0]        x_rdata [2];
    logic [INW-1:0]        w_rdata [2];

    assign k_clamped = K_BITS'(clamp_k(32'(AXIS_TUSER[K_BITS:1]), 32'(MAXK)));
    assign w_last    = CNT_BITS'(cur_k_q) * CNT_BITS'(cur_k_q) - CNT_BITS'(1);
    // New weights go to the W bank that the other X bank does not point at
    assign w_sel_new = ~x_wsel_q[~wr_bank_q];

    assign inputs_loaded = (bank_q[rd_bank_q] == FULL);
    assign K             = x_k_q[rd_bank_q];
    assign B             = x_b_q[rd_bank_q];
    assign AXIS_TREADY   = tready;
    assign X_data        = x_rdata[x_sel_q];
    assign W_data        = w_rdata[w_sel_q];

    // Load sequencing, bank occupancy and read-side release
    always_comb begin
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        cnt_d       = cnt_q;
        cur_k_d     = cur_k_q;
        cur_wsel_d  = cur_wsel_q;
        cur_b_d     = cur_b_q;
        last_k_d    = last_k_q;
        last_wsel_d = last_wsel_q;
        last_b_d    = last_b_q;
        bank_d      = bank_q;
        x_k_d       = x_k_q;
        x_wsel_d    = x_wsel_q;
        x_b_d       = x_b_q;
        x_we        = 1'b0;
        w_we        = 1'b0;
        w_bank_wr   = cur_wsel_q;
        tready      = 1'b0;

        case (state_q)
            IDLE:                   tready = rdy_q && (bank_q[wr_bank_q] == EMPTY);
            W_LOAD, B_LOAD, X_LOAD: tready = 1'b1;
            default:                tready = 1'b0;
        endcase
        tready = tready && !reset;
        beat   = tready && AXIS_TVALID;

        // Release the active bank; handled first so a simultaneous load completion sees it
        if (compute_finished && inputs_loaded) begin
            bank_d[rd_bank_q] = EMPTY;
            rd_bank_d         = ~rd_bank_q;
        end

        case (state_q)
            IDLE: begin
                if (beat) begin
                    if (AXIS_TUSER[0]) begin
                        cur_k_d    = k_clamped;
                        cur_wsel_d = w_sel_new;
                        w_bank_wr  = w_sel_new;
                        w_we       = 1'b1;
                        if (k_clamped == K_BITS'(1)) begin
                            cnt_d   = '0;
                            state_d = B_LOAD;
                        end else begin
                            cnt_d   = CNT_BITS'(1);
                            state_d = W_LOAD;
                        end
                    end else begin
                        cur_k_d    = last_k_q;
                        cur_wsel_d = last_wsel_q;
                        cur_b_d    = last_b_q;
                        x_we       = 1'b1;
                        cnt_d      = CNT_BITS'(1);
                        state_d    = X_LOAD;
                    end
                end
            end
            W_LOAD: begin
                if (beat) begin
                    w_we = 1'b1;
                    if (cnt_q == w_last) begin
                        cnt_d   = '0;
                        state_d = B_LOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
            end
            B_LOAD: begin
                if (beat) begin
                    cur_b_d = AXIS_TDATA;
                    cnt_d   = '0;
                    state_d = X_LOAD;
                end
            end
            X_LOAD: begin
                if (beat) begin
                    x_we = 1'b1;
                    if (cnt_q == X_LAST) begin
                        bank_d[wr_bank_q]   = FULL;
                        x_k_d[wr_bank_q]    = cur_k_q;
                        x_wsel_d[wr_bank_q] = cur_wsel_q;
                        x_b_d[wr_bank_q]    = cur_b_q;
                        last_k_d            = cur_k_q;
                        last_wsel_d         = cur_wsel_q;
                        last_b_d            = cur_b_q;
                        wr_bank_d           = ~wr_bank_q;
                        cnt_d               = '0;
                        state_d             = (bank_d[~wr_bank_q] == EMPTY) ? IDLE : WAIT_FREE;
                    end else begin
                        cnt_d = cnt_q + CNT_BITS'(1);
                    end
                end
            end
            WAIT_FREE: begin
                if (bank_d[wr_bank_q] == EMPTY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards every set and holds TREADY low for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bank_q[0]   <= EMPTY;
            bank_q[1]   <= EMPTY;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            rdy_q       <= 1'b0;
            cnt_q       <= '0;
            cur_k_q     <= '0;
            cur_wsel_q  <= 1'b0;
            cur_b_q     <= '0;
            last_k_q    <= '0;
            last_wsel_q <= 1'b0;
            last_b_q    <= '0;
            x_k_q[0]    <= '0;
            x_k_q[1]    <= '0;
            x_wsel_q[0] <= 1'b0;
            x_wsel_q[1] <= 1'b0;
            x_b_q[0]    <= '0;
            x_b_q[1]    <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            rdy_q       <= 1'b1;
            cnt_q       <= cnt_d;
            cur_k_q     <= cur_k_d;
            cur_wsel_q  <= cur_wsel_d;
            cur_b_q     <= cur_b_d;
            last_k_q    <= last_k_d;
            last_wsel_q <= last_wsel_d;
            last_b_q    <= last_b_d;
            x_k_q       <= x_k_d;
            x_wsel_q    <= x_wsel_d;
            x_b_q       <= x_b_d;
        end
    end

    // Output-mux selects track the bank that was active when the read was issued
    always_ff @(posedge clk) begin
        if (reset) begin
            x_sel_q <= 1'b0;
            w_sel_q <= 1'b0;
        end else begin
            x_sel_q <= rd_bank_q;
            w_sel_q <= x_wsel_q[rd_bank_q];
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        input_mems_pingpong_mem #(
            .WIDTH     (INW),
            .DEPTH     (R * C),
            .ADDR_BITS (X_ADDR_BITS)
        ) u_x_mem (
            .clk     (clk),
            .we_i    (x_we && (wr_bank_q == 1'(b))),
            .waddr_i (cnt_q[X_ADDR_BITS-1:0]),
            .wdata_i (AXIS_TDATA),
            .raddr_i (X_read_addr),
            .rdata_o (x_rdata[b])
        );

        input_mems_pingpong_mem #(
            .WIDTH     (INW),
            .DEPTH     (MAXK * MAXK),
            .ADDR_BITS (W_ADDR_BITS)
        ) u_w_mem (
            .clk     (clk),
            .we_i    (w_we && (w_bank_wr == 1'(b))),
            .waddr_i (cnt_q[W_ADDR_BITS-1:0]),
            .wdata_i (AXIS_TDATA),
            .raddr_i (W_read_addr),
            .rdata_o (w_rdata[b])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_input_mems_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_mems_pingpong
// Brief    : Self-checking bench for input_mems_pingpong using a set-level
//            queue model of the loaded banks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_mems_pingpong;

    localparam int INW  = 24;
    localparam int MAXK = 4;
    localparam int NX   = 72;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] AXIS_TDATA = '0;
    logic        AXIS_TVALID = 1'b0;
    logic [3:0]  AXIS_TUSER = '0;
    logic        AXIS_TREADY;
    logic        inputs_loaded;
    logic        compute_finished = 1'b0;
    logic [2:0]  K;
    logic signed [23:0] B;
    logic [6:0]  X_read_addr = '0;
    logic signed [23:0] X_data;
    logic [3:0]  W_read_addr = '0;
    logic signed [23:0] W_data;

    input_mems_pingpong #(.INW(INW), .R(9), .C(8), .MAXK(MAXK)) dut (
        .clk              (clk),
        .reset            (reset),
        .AXIS_TDATA       (AXIS_TDATA),
        .AXIS_TVALID      (AXIS_TVALID),
        .AXIS_TUSER       (AXIS_TUSER),
        .AXIS_TREADY      (AXIS_TREADY),
        .inputs_loaded    (inputs_loaded),
        .compute_finished (compute_finished),
        .K                (K),
        .B                (B),
        .X_read_addr      (X_read_addr),
        .X_data           (X_data),
        .W_read_addr      (W_read_addr),
        .W_data           (W_data)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Model: FIFO (depth 2) of complete sets awaiting/under compute
    logic [23:0] mx [2][NX];
    logic [23:0] mw [2][16];
    int          mk [2];
    logic [23:0] mb [2];
    bit          mwv [2];
    int          head = 0;
    int          count = 0;
    // Last completed set's W/K/B (reused by new_W=0)
    logic [23:0] lw [16];
    int          lk = 0;
    logic [23:0] lb = '0;
    bit          lwv = 1'b0;
    // Set being sent
    logic [23:0] px [NX];
    logic [23:0] pw [16];
    int          pk;
    logic [23:0] pb;
    bit          pwv;

    typedef struct {
        bit nw;
        int kraw;
        int exp_k;
        bit exp_b_zero;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; AXIS_TVALID = 1'b0; compute_finished = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        head = 0; count = 0; lk = 0; lb = '0; lwv = 1'b0;
        chk("rst_tready_low", {31'd0, AXIS_TREADY}, 32'd0);
        chk("rst_loaded", {31'd0, inputs_loaded}, 32'd0);
        chk("rst_K", {29'd0, K}, 32'd0);
        chk("rst_B", {8'd0, B}, 32'd0);
        @(negedge clk);
        chk("rst_tready_high", {31'd0, AXIS_TREADY}, 32'd1);
    endtask

    // Sends one set (or only its first 'limit' beats when limit>0)
    task automatic send_set(input bit nw, input int kraw, input bit cf_last,
                            input bit gaps, input bit fixed, input int limit);
        int nww;
        int nbeats;
        logic [23:0] d;
        if (nw) begin
            pk  = (kraw == 0) ? 1 : ((kraw > MAXK) ? MAXK : kraw);
            pb  = fixed ? 24'hFFFFFB : 24'($urandom);
            pwv = 1'b1;
            for (int i = 0; i < 16; i++) pw[i] = fixed ? 24'(100 + i) : 24'($urandom);
            nww = pk * pk;
        end else begin
            pk = lk; pb = lb; pwv = lwv;
            for (int i = 0; i < 16; i++) pw[i] = lw[i];
            nww = 0;
        end
        for (int i = 0; i < NX; i++) px[i] = fixed ? 24'(i) : 24'($urandom);
        nbeats = nw ? (nww + 1 + NX) : NX;
        for (int i = 0; i < nbeats; i++) begin
            bit last;
            int guard;
            if (limit > 0 && i >= limit) break;
            last = (i == nbeats - 1);
            if (nw && i < nww) d = pw[i];
            else if (nw && i == nww) d = pb;
            else d = px[i - (nw ? nww + 1 : 0)];
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk);
                AXIS_TVALID = 1'b0;
            end
            @(negedge clk);
            AXIS_TDATA  = d;
            AXIS_TVALID = 1'b1;
            AXIS_TUSER  = (i == 0) ? {3'(kraw), nw} : 4'h0;
            compute_finished = cf_last && last;
            if (last) chk("loaded_before_last", {31'd0, inputs_loaded}, (count > 0) ? 32'd1 : 32'd0);
            guard = 0;
            while (!AXIS_TREADY && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            if (!AXIS_TREADY) chk("tready_timeout", {31'd0, AXIS_TREADY}, 32'd1);
            @(posedge clk);
        end
        @(negedge clk);
        AXIS_TVALID = 1'b0;
        compute_finished = 1'b0;
        if (limit > 0 && limit < nbeats) return;
        if (cf_last && count > 0) begin
            head = 1 - head;
            count--;
        end
        begin
            int s;
            s = (head + count) % 2;
            for (int i = 0; i < NX; i++) mx[s][i] = px[i];
            for (int i = 0; i < 16; i++) mw[s][i] = pw[i];
            mk[s] = pk; mb[s] = pb; mwv[s] = pwv;
            count++;
        end
        lk = pk; lb = pb; lwv = pwv;
        for (int i = 0; i < 16; i++) lw[i] = pw[i];
        chk("loaded_after_last", {31'd0, inputs_loaded}, 32'd1);
        chk("tready_after_set", {31'd0, AXIS_TREADY}, (count < 2) ? 32'd1 : 32'd0);
    endtask

    task automatic compute_finish();
        @(negedge clk);
        compute_finished = 1'b1;
        @(negedge clk);
        compute_finished = 1'b0;
        if (count > 0) begin
            head = 1 - head;
            count--;
        end
        chk("loaded_after_finish", {31'd0, inputs_loaded}, (count > 0) ? 32'd1 : 32'd0);
    endtask

    task automatic check_front(input string tag);
        chk({tag, "_loaded"}, {31'd0, inputs_loaded}, (count > 0) ? 32'd1 : 32'd0);
        if (count > 0) begin
            chk({tag, "_K"}, {29'd0, K}, 32'(mk[head]));
            chk({tag, "_B"}, {8'd0, B}, {8'd0, mb[head]});
            for (int r = 0; r < 3; r++) begin
                int xa;
                int wa;
                int kk;
                kk = mk[head] * mk[head];
                xa = (r == 0) ? 0 : ((r == 1) ? NX - 1 : int'($urandom_range(0, NX - 1)));
                wa = (kk == 0) ? 0 : ((r == 0) ? 0 : ((r == 1) ? kk - 1 : int'($urandom_range(0, kk - 1))));
                @(negedge clk);
                X_read_addr = 7'(xa);
                W_read_addr = 4'(wa);
                @(negedge clk);
                chk({tag, "_X"}, {8'd0, X_data}, {8'd0, mx[head][xa]});
                if (mwv[head] && kk > 0) chk({tag, "_W"}, {8'd0, W_data}, {8'd0, mw[head][wa]});
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{nw: 1'b0, kraw: 5, exp_k: 0, exp_b_zero: 1'b1};
        vecs[1] = '{nw: 1'b1, kraw: 3, exp_k: 3, exp_b_zero: 1'b0};
        vecs[2] = '{nw: 1'b1, kraw: 0, exp_k: 1, exp_b_zero: 1'b0};
        vecs[3] = '{nw: 1'b1, kraw: 7, exp_k: 4, exp_b_zero: 1'b0};
        vecs[4] = '{nw: 1'b1, kraw: 2, exp_k: 2, exp_b_zero: 1'b0};
        vecs[5] = '{nw: 1'b1, kraw: 4, exp_k: 4, exp_b_zero: 1'b0};
        vecs[6] = '{nw: 1'b0, kraw: 1, exp_k: 4, exp_b_zero: 1'b0};

        do_reset();

        // Table: K clamping, W reuse, no-prior-W after reset
        for (int v = 0; v < 7; v++) begin
            send_set(vecs[v].nw, vecs[v].kraw, 1'b0, 1'b1, 1'b0, 0);
            chk("vec_K", {29'd0, K}, 32'(vecs[v].exp_k));
            if (vecs[v].exp_b_zero) chk("vec_B_zero", {8'd0, B}, 32'd0);
            check_front("vec");
            compute_finish();
        end
        compute_finish();

        // Set with known contents: K=3, B=-5, X=index
        send_set(1'b1, 3, 1'b0, 1'b0, 1'b1, 0);
        chk("t1_K", {29'd0, K}, 32'd3);
        chk("t1_B", {8'd0, B}, {8'd0, 24'hFFFFFB});
        @(negedge clk);
        X_read_addr = 7'd10;
        @(negedge clk);
        chk("t1_X10", {8'd0, X_data}, 32'd10);

        // Preload a reuse-W set while computing, then hand over
        send_set(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
        check_front("t2_pre");
        compute_finish();
        chk("t2_K", {29'd0, K}, 32'd3);
        check_front("t2_post");
        compute_finish();

        // New W during compute must not disturb the active W bank
        send_set(1'b1, 3, 1'b0, 1'b1, 1'b0, 0);
        send_set(1'b1, 2, 1'b0, 1'b1, 1'b0, 0);
        check_front("t3_pre");
        compute_finish();
        chk("t3_K", {29'd0, K}, 32'd2);
        check_front("t3_post");
        compute_finish();

        // Release coincides with the last X beat of the next set
        send_set(1'b1, 4, 1'b0, 1'b1, 1'b0, 0);
        send_set(1'b0, 0, 1'b1, 1'b1, 1'b0, 0);
        check_front("t4");
        compute_finish();

        // Reset mid-load, then mid-compute
        send_set(1'b1, 2, 1'b0, 1'b0, 1'b0, 20);
        do_reset();
        send_set(1'b1, 3, 1'b0, 1'b1, 1'b0, 0);
        check_front("t6_load");
        do_reset();
        send_set(1'b0, 2, 1'b0, 1'b1, 1'b0, 0);
        chk("t6_noW_K", {29'd0, K}, 32'd0);
        chk("t6_noW_B", {8'd0, B}, 32'd0);
        compute_finish();
        send_set(1'b1, 4, 1'b0, 1'b1, 1'b0, 0);
        check_front("t6_after");
        compute_finish();

        // Randomised mix of loads, preloads and releases
        for (int it = 0; it < 14; it++) begin
            if (count == 2 || (count > 0 && $urandom_range(0, 2) == 0)) begin
                compute_finish();
            end else begin
                send_set(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                         (count == 1) && ($urandom_range(0, 1) == 1), 1'b1, 1'b0, 0);
            end
            check_front("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
